// File: rtl/fsm_serial_tx.sv
// Moore-FSM serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define FSM_SERIAL_TX_PARITY_EN to insert an odd-parity bit between data and stop.
module fsm_serial_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef FSM_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
`ifdef FSM_SERIAL_TX_PARITY_EN
  logic              parity_reg, parity_next;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
`ifdef FSM_SERIAL_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
`ifdef FSM_SERIAL_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // All outputs decode from registered state only; valid/data affect next state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    shreg_next = shreg_reg;
`ifdef FSM_SERIAL_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    ready = 1'b0;
    out   = 1'b1;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          state_next = START;
          shreg_next = data;
`ifdef FSM_SERIAL_TX_PARITY_EN
          parity_next = ~(^data);
`endif
        end
      end
      START: begin
        out        = 1'b0;
        busy       = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        out        = shreg_reg[0];
        busy       = 1'b1;
        shreg_next = shreg_reg >> 1;
        if (cnt_reg == LAST_BIT) begin
`ifdef FSM_SERIAL_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef FSM_SERIAL_TX_PARITY_EN
      PARITY: begin
        out        = parity_reg;
        busy       = 1'b1;
        state_next = STOP;
      end
`endif
      STOP: begin
        ready = 1'b1;
        busy  = 1'b1;
        done  = 1'b1;
        // A handshake here chains the next frame with no idle gap.
        if (valid) begin
          state_next = START;
          shreg_next = data;
`ifdef FSM_SERIAL_TX_PARITY_EN
          parity_next = ~(^data);
`endif
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/fsm_serial_tx.md
FSM_SERIAL_TX -- requirements
Module: fsm_serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: number of data bits per frame, legal range 5..9.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-low (0 = reset, sampled on rising clk).
REQ-004 SHALL have port data, input, DATA_W bits: parallel byte to serialize; sampled only at handshake.
REQ-005 SHALL have port valid, input, 1 bit: requester asserts when data is valid.
REQ-006 SHALL have port ready, output, 1 bit: block can accept data this cycle.
REQ-007 SHALL have port out, output, 1 bit: serial line; idle level 1.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is on the line (START through STOP).
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse during the STOP bit cycle.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, START, DATA, PARITY (only when PARITY_EN is defined), STOP.
REQ-011 SHALL transfer a word when valid=1 and ready=1 at a rising clk edge (handshake); data latched into an internal DATA_W-bit shift register on that edge.
REQ-012 SHALL drive ready=1 in IDLE and STOP, 0 in START, DATA, PARITY.
REQ-013 SHALL transition IDLE->START on handshake, else remain IDLE.
REQ-014 SHALL spend exactly 1 cycle in START with out=0.
REQ-015 SHALL spend exactly DATA_W cycles in DATA, LSB first: out = shift register bit 0, register shifted right once per DATA cycle; bit counter 0..DATA_W-1, cleared outside DATA.
REQ-016 SHALL leave DATA after the cycle with counter=DATA_W-1, to PARITY if enabled, else STOP.
REQ-017 SHALL spend exactly 1 cycle in STOP with out=1, done=1.
REQ-018 SHALL transition STOP->START if handshake occurs in STOP (back-to-back frames, no idle gap), else STOP->IDLE.
REQ-019 SHALL drive out=1, busy=0, done=0 in IDLE.
REQ-020 SHALL derive out, busy, done, ready solely from registered state (no combinational path from valid or data to out).
REQ-021 SHALL ignore valid and data changes while ready=0; a word presented during a frame is not lost only if the requester holds valid until ready.
REQ-022 SHALL give frame length 1+DATA_W+1 cycles (plus 1 with parity); first start bit appears on out the cycle after handshake.
REQ-023 SHALL force any illegal state encoding to IDLE on the next edge.

Reset
REQ-024 SHALL, with reset=0 at a rising edge, set state=IDLE, counter=0, shift register=0, regardless of current state, including mid-frame.
REQ-025 SHALL present after reset: out=1, ready=1, busy=0, done=0; the aborted frame is not resumed.
REQ-026 SHALL give reset priority over a simultaneous handshake (word discarded).

Configuration
REQ-027 SHALL, when macro FSM_SERIAL_TX_PARITY_EN is defined, insert a PARITY state after DATA lasting 1 cycle, out = odd parity bit (XOR of all data bits inverted, so total ones in data+parity is odd), then go to STOP.
REQ-028 SHALL, when FSM_SERIAL_TX_PARITY_EN is undefined, contain no PARITY state or parity logic; DATA goes directly to STOP.

Verification
REQ-029 SHALL check single frame: reset released, data=0xA5 valid one cycle -> out over next 10 cycles = 0,1,0,1,0,0,1,0,1,1; done=1 only on 10th; then out=1, ready=1.
REQ-030 SHALL check back-to-back: 0x00 then 0xFF, valid held -> 20 contiguous cycles 0,00000000,1,0,11111111,1 with no idle cycle; second handshake in STOP of first frame.
REQ-031 SHALL check busy-ignore: handshake 0x3C, then valid=1 with data=0xFF during cycles 2..8 -> transmitted bits match 0x3C; 0xFF accepted only at STOP.
REQ-032 SHALL check reset mid-frame: reset=0 during 4th DATA cycle of 0x81 -> next cycle out=1, ready=1, busy=0; no done pulse.
REQ-033 SHALL check parity build: FSM_SERIAL_TX_PARITY_EN defined, 0xA5 -> 11 cycles 0,10100101,1,1 (parity=1); 0x07 -> parity bit=0.
REQ-034 SHALL check idle hold: valid=0 for 50 cycles after reset -> out=1, busy=0, done=0 throughout.
